// File: rtl/arm_wb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
// The pending-result hazard comparators are built only when WB_ARB_HAZARD_EN is defined.
package arm_wb_pkg;

    localparam int WB_DATA_W     = 32;
    localparam int WB_ADDR_W     = 4;
    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_MAX_WAIT   = 3;

    typedef enum logic {
        PIPE_PRI = 1'b0,
        FORCE    = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] value;
    } wb_req_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Circular buffer of pending multi-cycle results; exposes the head entry and every
// slot's destination with a per-slot valid flag so the owner can run hazard checks.
module wb_pend_fifo
    import arm_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [ADDR_W-1:0]        i_push_dest,
    input  logic [DATA_W-1:0]        i_push_value,
    input  logic                     i_pop,
    output logic [ADDR_W-1:0]        o_head_dest,
    output logic [DATA_W-1:0]        o_head_value,
    output logic [CNT_W-1:0]         o_count,
    output logic [DEPTH-1:0]         o_entry_valid,
    output logic [DEPTH*ADDR_W-1:0]  o_entry_dest
);

    logic [ADDR_W-1:0] r_dest_mem  [DEPTH];
    logic [DATA_W-1:0] r_value_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage carries no reset: only pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_dest_mem[r_wr_ptr]  <= i_push_dest;
            r_value_mem[r_wr_ptr] <= i_push_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dest  = r_dest_mem[r_rd_ptr];
    assign o_head_value = r_value_mem[r_rd_ptr];
    assign o_count      = r_count;

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        localparam logic [PTR_W-1:0] SLOT_IDX = PTR_W'(gi);
        logic [PTR_W-1:0] w_offset;
        assign w_offset          = SLOT_IDX - r_rd_ptr;
        assign o_entry_valid[gi] = ({1'b0, w_offset} < r_count);
        assign o_entry_dest[gi*ADDR_W +: ADDR_W] = r_dest_mem[gi];
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline WB stage and buffered multi-cycle
// results; WB_ARB_HAZARD_EN enables the decode-source vs pending-destination hazard output.
module wb_port_arbiter
    import arm_wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int MAX_WAIT   = WB_MAX_WAIT,
    localparam int CNT_W     = cnt_w(FIFO_DEPTH),
    localparam int WAIT_W    = $clog2(MAX_WAIT + 1)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pipe_wb_en,
    input  logic [ADDR_W-1:0] i_pipe_wb_dest,
    input  logic [DATA_W-1:0] i_pipe_wb_value,
    input  logic              i_mc_valid,
    output logic              o_mc_ready,
    input  logic [ADDR_W-1:0] i_mc_dest,
    input  logic [DATA_W-1:0] i_mc_value,
    input  logic [ADDR_W-1:0] i_src1,
    input  logic [ADDR_W-1:0] i_src2,
    output logic              o_hazard,
    output logic              o_pipe_stall,
    output logic              o_rf_we,
    output logic [ADDR_W-1:0] o_rf_dest,
    output logic [DATA_W-1:0] o_rf_value,
    output logic [CNT_W-1:0]  o_fifo_count
);

    arb_state_t                r_state;
    arb_state_t                w_state_next;
    logic [WAIT_W-1:0]         r_wait_cnt;
    logic                      r_rf_we;
    logic [ADDR_W-1:0]         r_rf_dest;
    logic [DATA_W-1:0]         r_rf_value;

    logic                      w_force;
    logic                      w_fifo_ne;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_grant_pipe;
    logic [CNT_W-1:0]          w_count;
    logic [ADDR_W-1:0]         w_head_dest;
    logic [DATA_W-1:0]         w_head_value;
    logic [FIFO_DEPTH-1:0]     w_entry_valid;
    logic [FIFO_DEPTH*ADDR_W-1:0] w_entry_dest;

    wb_pend_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_push_dest   (i_mc_dest),
        .i_push_value  (i_mc_value),
        .i_pop         (w_pop),
        .o_head_dest   (w_head_dest),
        .o_head_value  (w_head_value),
        .o_count       (w_count),
        .o_entry_valid (w_entry_valid),
        .o_entry_dest  (w_entry_dest)
    );

    // Readiness looks only at the current count, so a full FIFO refuses even on a pop cycle.
    assign o_mc_ready   = (w_count < CNT_W'(FIFO_DEPTH));
    assign w_push       = i_mc_valid && o_mc_ready;
    assign w_fifo_ne    = (w_count != '0);
    assign o_fifo_count = w_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PIPE_PRI;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = PIPE_PRI;
        if (r_state == PIPE_PRI && i_pipe_wb_en && w_fifo_ne &&
            r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            w_state_next = FORCE;
        end
    end

    always_comb begin
        w_force      = (r_state == FORCE);
        o_pipe_stall = w_force;
    end

    // In FORCE the pipeline request is ignored; it is re-presented on the following cycle.
    always_comb begin
        w_grant_pipe = !w_force && i_pipe_wb_en;
        w_pop        = w_fifo_ne && (w_force || !i_pipe_wb_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_pop) begin
            r_wait_cnt <= '0;
        end else if (w_fifo_ne && r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_dest  <= '0;
            r_rf_value <= '0;
        end else begin
            r_rf_we <= w_grant_pipe || w_pop;
            if (w_grant_pipe) begin
                r_rf_dest  <= i_pipe_wb_dest;
                r_rf_value <= i_pipe_wb_value;
            end else if (w_pop) begin
                r_rf_dest  <= w_head_dest;
                r_rf_value <= w_head_value;
            end
        end
    end

    assign o_rf_we    = r_rf_we;
    assign o_rf_dest  = r_rf_dest;
    assign o_rf_value = r_rf_value;

`ifdef WB_ARB_HAZARD_EN
    logic [FIFO_DEPTH-1:0] w_match;
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hazard
        logic [ADDR_W-1:0] w_slot_dest;
        assign w_slot_dest = w_entry_dest[gi*ADDR_W +: ADDR_W];
        assign w_match[gi] = w_entry_valid[gi] &&
                             ((w_slot_dest == i_src1) || (w_slot_dest == i_src2));
    end
    assign o_hazard = |w_match;
`else
    logic w_unused_hazard;
    assign w_unused_hazard = ^{i_src1, i_src2, w_entry_valid, w_entry_dest};
    assign o_hazard        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// each cycle's register-file write; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_wb_port_arbiter;
    import arm_wb_pkg::*;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;
    localparam int CNT_W    = 3;
    localparam int N_CYC    = 400;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_pipe_wb_en;
    logic [ADDR_W-1:0] i_pipe_wb_dest;
    logic [DATA_W-1:0] i_pipe_wb_value;
    logic              i_mc_valid;
    logic              o_mc_ready;
    logic [ADDR_W-1:0] i_mc_dest;
    logic [DATA_W-1:0] i_mc_value;
    logic [ADDR_W-1:0] i_src1;
    logic [ADDR_W-1:0] i_src2;
    logic              o_hazard;
    logic              o_pipe_stall;
    logic              o_rf_we;
    logic [ADDR_W-1:0] o_rf_dest;
    logic [DATA_W-1:0] o_rf_value;
    logic [CNT_W-1:0]  o_fifo_count;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_pipe_wb_en    (i_pipe_wb_en),
        .i_pipe_wb_dest  (i_pipe_wb_dest),
        .i_pipe_wb_value (i_pipe_wb_value),
        .i_mc_valid      (i_mc_valid),
        .o_mc_ready      (o_mc_ready),
        .i_mc_dest       (i_mc_dest),
        .i_mc_value      (i_mc_value),
        .i_src1          (i_src1),
        .i_src2          (i_src2),
        .o_hazard        (o_hazard),
        .o_pipe_stall    (o_pipe_stall),
        .o_rf_we         (o_rf_we),
        .o_rf_dest       (o_rf_dest),
        .o_rf_value      (o_rf_value),
        .o_fifo_count    (o_fifo_count)
    );

    typedef struct packed {
        logic    we;
        wb_req_t req;
    } rf_exp_t;

    int      errors = 0;
    int      checks = 0;
    bit      mon_en = 1'b0;
    rf_exp_t sb[$];

    // Reference model: pending results, denied-cycle count of the head, forced-grant flag.
    wb_req_t m_q[$];
    int      m_waited = 0;
    bit      m_force  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        rf_exp_t e;
        int      n;
        bit      popped;
        bit      denied;
        e      = '0;
        n      = m_q.size();
        popped = 1'b0;
        if (m_force) begin
            e.we = 1'b1; e.req = m_q[0]; popped = 1'b1;
        end else if (i_pipe_wb_en) begin
            e.we = 1'b1; e.req.dest = i_pipe_wb_dest; e.req.value = i_pipe_wb_value;
        end else if (n > 0) begin
            e.we = 1'b1; e.req = m_q[0]; popped = 1'b1;
        end
        denied = (n > 0) && !popped;
        if (popped) begin
            void'(m_q.pop_front());
            m_waited = 0;
        end else if (denied && m_waited < MAX_WAIT) begin
            m_waited++;
        end
        // Head denied for MAX_WAIT cycles: next cycle it takes the port by force.
        m_force = denied && !m_force && (m_waited == MAX_WAIT);
        if (i_mc_valid && n < DEPTH) begin
            m_q.push_back({i_mc_dest, i_mc_value});
        end
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_waited = 0;
                m_force  = 1'b0;
                sb.delete();
                sb.push_back('0);
            end else begin
                model_step();
            end
        end
    end

    rf_exp_t mon_e;
    bit      mon_haz;
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                if (mon_en) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
                end
            end else begin
                mon_e = sb.pop_front();
                if (mon_en) begin
                    check("rf_we", o_rf_we, mon_e.we);
                    if (mon_e.we) begin
                        check("rf_dest", o_rf_dest, mon_e.req.dest);
                        check("rf_value", o_rf_value, mon_e.req.value);
                        $display("rf write dest=%0d value=%08h", mon_e.req.dest, mon_e.req.value);
                    end
                    check("fifo_count", o_fifo_count, m_q.size());
                    check("mc_ready", o_mc_ready, m_q.size() < DEPTH);
                    check("pipe_stall", o_pipe_stall, m_force);
                    mon_haz = 1'b0;
`ifdef WB_ARB_HAZARD_EN
                    foreach (m_q[k]) begin
                        if (m_q[k].dest == i_src1 || m_q[k].dest == i_src2) mon_haz = 1'b1;
                    end
`endif
                    check("hazard", o_hazard, mon_haz);
                end
            end
        end
    end

    bit done_rst = 1'b0;
    initial begin
        i_pipe_wb_en = 0; i_pipe_wb_dest = '0; i_pipe_wb_value = '0;
        i_mc_valid = 0; i_mc_dest = '0; i_mc_value = '0;
        i_src1 = '0; i_src2 = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        mon_en = 1'b1;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #2;
            i_src1 = ADDR_W'($urandom_range(0, 7));
            i_src2 = ADDR_W'($urandom_range(0, 7));
            if (!m_force) begin
                i_pipe_wb_dest  = ADDR_W'($urandom_range(0, 15));
                i_pipe_wb_value = $urandom;
            end
            i_mc_dest  = ADDR_W'($urandom_range(0, 7));
            i_mc_value = $urandom;
            if (cyc == 0) begin
                i_pipe_wb_en = 1; i_pipe_wb_dest = 4'd3; i_pipe_wb_value = 32'h1234;
                i_mc_valid = 0;
            end else if (cyc == 1) begin
                i_pipe_wb_en = 0; i_mc_valid = 1; i_mc_dest = 4'd5; i_mc_value = 32'hAA;
            end else if (cyc < 4) begin
                i_pipe_wb_en = 0; i_mc_valid = 0;
            end else if (cyc < 120 || cyc >= 260) begin
                if (!m_force) i_pipe_wb_en = $urandom_range(0, 1) == 1;
                i_mc_valid = $urandom_range(0, 1) == 1;
            end else if (cyc < 200) begin
                // Pipeline saturated: FIFO fills and only forced grants drain it.
                i_pipe_wb_en = 1;
                i_mc_valid   = $urandom_range(0, 9) < 6;
            end else begin
                if (!m_force) i_pipe_wb_en = 0;
                i_mc_valid = $urandom_range(0, 3) == 0;
            end
            if (!done_rst && cyc >= 150 && m_q.size() >= 2) begin
                done_rst = 1'b1;
                #1 rst_n = 1'b0;
                #1;
                check("rst_fifo_count", o_fifo_count, 0);
                check("rst_rf_we", o_rf_we, 0);
                check("rst_pipe_stall", o_pipe_stall, 0);
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
